// File: rtl/alu_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rr_sequencer
//  Purpose  : Shares one combinational ALU between two requesters using
//             round-robin arbitration. Each requester has its own valid/ready
//             command channel. Results return on one shared valid/ready
//             response channel, tagged with the requester id.
//  Option   : define ALU_OPCHK_EN to flag unsupported opcodes on rsp_err.
//             When it is flagged, the result and zero flag are forced to 0.
//  Revision : 1.0  initial release
// ============================================================================
module alu_rr_sequencer #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  // ALU side
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  // shared response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  // status
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [OP_W-1:0]     op_q;
  logic                id_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_zero_q;
  logic [CNT_W-1:0]    op_count_q;

  logic                grant0, grant1;
  logic                acc0, acc1;
  logic                rsp_hs;
  logic [DATA_W-1:0]   exec_result;
  logic                exec_zero;

  // Round-robin arbitration and the next-state decision. A requester that is
  // not contending wins outright; on contention the one not granted last wins.
  always_comb begin
    state_d    = state_q;
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant0     = req0_valid && (!req1_valid || last_grant_q);
        grant1     = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign acc0   = req0_valid && req0_ready;
  assign acc1   = req1_valid && req1_ready;
  assign rsp_hs = rsp_valid_q && rsp_ready;

`ifdef ALU_OPCHK_EN
  logic rsp_err_q;
  logic op_illegal;

  // Only AND, OR, ADD, SUB and NOR are supported by the attached ALU.
  always_comb begin
    op_illegal = !((op_q == OP_W'(4'b0000)) || (op_q == OP_W'(4'b0001)) ||
                   (op_q == OP_W'(4'b0010)) || (op_q == OP_W'(4'b0110)) ||
                   (op_q == OP_W'(4'b1100)));
    exec_result = op_illegal ? '0 : alu_result;
    exec_zero   = op_illegal ? 1'b0 : alu_zero;
  end

  // Error flag is captured alongside the result at the end of EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 rsp_err_q <= 1'b0;
    else if (state_q == S_EXEC) rsp_err_q <= op_illegal;
  end

  assign rsp_err = rsp_err_q;
`else
  assign exec_result = alu_result;
  assign exec_zero   = alu_zero;
  assign rsp_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Command latch, response capture and completion counter. The latched
  // operands also feed the ALU directly, so they hold still while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      if (acc0 || acc1) begin
        a_q          <= acc1 ? req1_a  : req0_a;
        b_q          <= acc1 ? req1_b  : req0_b;
        op_q         <= acc1 ? req1_op : req0_op;
        id_q         <= acc1;
        last_grant_q <= acc1;
      end
      if (state_q == S_EXEC) begin
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= id_q;
        rsp_result_q <= exec_result;
        rsp_zero_q   <= exec_zero;
      end
      if (state_q == S_RESP && rsp_hs) begin
        rsp_valid_q <= 1'b0;
        op_count_q  <= op_count_q + 1'b1;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state_q != S_IDLE);
  assign op_count   = op_count_q;

endmodule
`default_nettype wire
